regb_fifo_chain: RTL and testbench

//  Complete register-based FIFO built from DEPTH register stages (stage 0 = output stage).

---
 rtl/regb_fifo_chain_if.sv | 32 +++
 rtl/regb_fifo_chain.sv | 101 ++++++++++
 tb/tb_regb_fifo_chain.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/regb_fifo_chain_if.sv
// Producer/consumer-side bundle for the register-chain FIFO.
// The FIFO uses the slave modport; the surrounding logic uses master.
interface regb_fifo_chain_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic             shift_in;
  logic [WIDTH-1:0] si;
  logic             shift_out;
  logic             flush;
  logic             clr_err;
  logic [WIDTH-1:0] out;
  logic             empty_n;
  logic             full;
  logic             almost_full;
  logic             almost_empty;
  logic [LVL_W-1:0] level;
  logic             overflow;
  logic             underflow;

  modport master (
    output shift_in, si, shift_out, flush, clr_err,
    input  out, empty_n, full, almost_full, almost_empty, level, overflow, underflow
  );

  modport slave (
    input  shift_in, si, shift_out, flush, clr_err,
    output out, empty_n, full, almost_full, almost_empty, level, overflow, underflow
  );
endinterface

// File: rtl/regb_fifo_chain.sv
// Register-chain FIFO: DEPTH stages compacting toward stage 0, with fill level,
// almost-full/empty thresholds, synchronous flush and sticky error flags.
module regb_fifo_chain #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AF_LEVEL = 3,
  parameter int unsigned AE_LEVEL = 1
) (
  input logic              clk,
  input logic              res,
  regb_fifo_chain_if.slave bus
);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [LVL_W-1:0] level_q, level_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             empty_n_q, full_q, af_q, ae_q;

  logic             is_full, is_empty;
  logic             do_push, do_pop;
  logic [LVL_W-1:0] wr_idx;

  // Next-state: shift toward stage 0 on pop, then write the pushed word at the new tail.
  always_comb begin
    data_d   = data_q;
    level_d  = level_q;
    ovf_d    = ovf_q & ~bus.clr_err;
    unf_d    = unf_q & ~bus.clr_err;
    is_full  = (level_q == LVL_W'(DEPTH));
    is_empty = (level_q == '0);
    do_pop   = 1'b0;
    do_push  = 1'b0;
    wr_idx   = level_q;

    if (bus.flush) begin
      level_d = '0;
    end else begin
      do_pop  = bus.shift_out & ~is_empty;
      do_push = bus.shift_in & (~is_full | do_pop);
      if (bus.shift_out && is_empty)                 unf_d = 1'b1;
      if (bus.shift_in && is_full && !bus.shift_out) ovf_d = 1'b1;

      if (do_pop) begin
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
          data_d[i] = data_q[i+1];
        end
        wr_idx = level_q - LVL_W'(1);
      end

      if (do_push) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (LVL_W'(i) == wr_idx) data_d[i] = bus.si;
        end
      end

      level_d = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
    end

    // Stage-0 data is only presented when it holds a valid entry.
    out_d = (level_d != '0) ? data_d[0] : '0;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= '0;
      end
      level_q   <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      out_q     <= '0;
      empty_n_q <= 1'b0;
      full_q    <= 1'b0;
      af_q      <= 1'b0;
      ae_q      <= 1'b1;
    end else begin
      data_q    <= data_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      out_q     <= out_d;
      empty_n_q <= (level_d != '0);
      full_q    <= (level_d == LVL_W'(DEPTH));
      af_q      <= (level_d >= LVL_W'(AF_LEVEL));
      ae_q      <= (level_d <= LVL_W'(AE_LEVEL));
    end
  end

  assign bus.out          = out_q;
  assign bus.empty_n      = empty_n_q;
  assign bus.full         = full_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.level        = level_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_regb_fifo_chain.sv
// Directed corner cases plus random traffic for regb_fifo_chain, checked
// against a queue-based reference model.
module tb_regb_fifo_chain;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AF    = 3;
  localparam int unsigned AE    = 1;

  logic clk = 1'b0;
  logic res = 1'b1;

  regb_fifo_chain_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  regb_fifo_chain #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk(clk),
    .res(res),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] mq [$];
  logic             m_ovf = 1'b0;
  logic             m_unf = 1'b0;
  int               total = 0;
  int               bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: FIFO as a queue; a push fits iff there is room after any pop.
  task automatic model(input logic p, input logic [WIDTH-1:0] d, input logic po,
                       input logic fl, input logic ce, input logic rs);
    logic e_ovf, e_unf;
    e_ovf = 1'b0;
    e_unf = 1'b0;
    if (rs) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (fl) begin
        mq.delete();
      end else begin
        if (po) begin
          if (mq.size() == 0) e_unf = 1'b1;
          else void'(mq.pop_front());
        end
        if (p) begin
          if (mq.size() < int'(DEPTH)) mq.push_back(d);
          else e_ovf = 1'b1;
        end
      end
      m_ovf = e_ovf | (m_ovf & ~ce);
      m_unf = e_unf | (m_unf & ~ce);
    end
  endtask

  task automatic check_model(input string tag);
    int n;
    logic [WIDTH-1:0] eo;
    n  = mq.size();
    eo = (n > 0) ? mq[0] : '0;
    chk({tag, ".out"},   32'(bus.out),          32'(eo));
    chk({tag, ".level"}, 32'(bus.level),        32'(n));
    chk({tag, ".empn"},  32'(bus.empty_n),      32'(n != 0));
    chk({tag, ".full"},  32'(bus.full),         32'(n == int'(DEPTH)));
    chk({tag, ".af"},    32'(bus.almost_full),  32'(n >= int'(AF)));
    chk({tag, ".ae"},    32'(bus.almost_empty), 32'(n <= int'(AE)));
    chk({tag, ".ovf"},   32'(bus.overflow),     32'(m_ovf));
    chk({tag, ".unf"},   32'(bus.underflow),    32'(m_unf));
  endtask

  // Drive one cycle of inputs away from the edge, clock it, then compare 1ns later.
  task automatic step(input string tag, input logic p, input logic [WIDTH-1:0] d,
                      input logic po, input logic fl, input logic ce, input logic rs);
    bus.shift_in  = p;
    bus.si        = d;
    bus.shift_out = po;
    bus.flush     = fl;
    bus.clr_err   = ce;
    res           = rs;
    @(posedge clk);
    #1;
    model(p, d, po, fl, ce, rs);
    check_model(tag);
  endtask

  task automatic push(input string tag, input logic [WIDTH-1:0] d);
    step(tag, 1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop(input string tag);
    step(tag, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input string tag, input logic ce);
    step(tag, 1'b0, '0, 1'b0, 1'b0, ce, 1'b0);
  endtask

  initial begin
    bus.shift_in  = 1'b0;
    bus.si        = '0;
    bus.shift_out = 1'b0;
    bus.flush     = 1'b0;
    bus.clr_err   = 1'b0;
    #1;

    step("rst0", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst0.ae_const", 32'(bus.almost_empty), 32'd1);

    // Reset mid-traffic with level 3
    push("t1.p", 8'h01); push("t1.p", 8'h02); push("t1.p", 8'h03);
    chk("t1.lvl3", 32'(bus.level), 32'd3);
    step("t1.rst", 1'b1, 8'h04, 1'b1, 1'b0, 1'b0, 1'b1);
    step("t1.rst", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t1.level", 32'(bus.level), 32'd0);
    chk("t1.out",   32'(bus.out),   32'd0);
    chk("t1.empn",  32'(bus.empty_n), 32'd0);

    // Fill, overflow, drain in order
    push("t2.p", 8'h11);
    chk("t2.lat", 32'(bus.out), 32'h11);
    push("t2.p", 8'h22);
    chk("t2.af2", 32'(bus.almost_full), 32'd0);
    push("t2.p", 8'h33);
    chk("t2.af3", 32'(bus.almost_full), 32'd1);
    push("t2.p", 8'h44);
    chk("t2.full", 32'(bus.full), 32'd1);
    chk("t2.lvl4", 32'(bus.level), 32'd4);
    push("t2.ovf", 8'h55);
    chk("t2.ovfset", 32'(bus.overflow), 32'd1);
    chk("t2.keep", 32'(bus.out), 32'h11);
    idle("t2.clr", 1'b1);
    chk("t2.ovfclr", 32'(bus.overflow), 32'd0);
    chk("t2.rd0", 32'(bus.out), 32'h11); pop("t2.pop");
    chk("t2.rd1", 32'(bus.out), 32'h22); pop("t2.pop");
    chk("t2.rd2", 32'(bus.out), 32'h33); pop("t2.pop");
    chk("t2.rd3", 32'(bus.out), 32'h44); pop("t2.pop");
    chk("t2.empty", 32'(bus.empty_n), 32'd0);

    // Simultaneous push+pop while full
    push("t3.p", 8'h11); push("t3.p", 8'h22); push("t3.p", 8'h33); push("t3.p", 8'h44);
    step("t3.pp", 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t3.out22", 32'(bus.out), 32'h22);
    chk("t3.lvl4", 32'(bus.level), 32'd4);
    chk("t3.noovf", 32'(bus.overflow), 32'd0);
    pop("t3.pop"); pop("t3.pop"); pop("t3.pop");
    chk("t3.a5", 32'(bus.out), 32'hA5);
    pop("t3.pop");

    // Push+pop while empty
    step("t4.pp", 1'b1, 8'h7E, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t4.out", 32'(bus.out), 32'h7E);
    chk("t4.lvl1", 32'(bus.level), 32'd1);
    chk("t4.unf", 32'(bus.underflow), 32'd1);
    idle("t4.clr", 1'b1);
    chk("t4.unfclr", 32'(bus.underflow), 32'd0);
    pop("t4.pop");

    // Flush with concurrent push+pop
    push("t5.p", 8'hC1); push("t5.p", 8'hC2); push("t5.p", 8'hC3);
    step("t5.fl", 1'b1, 8'hC4, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t5.lvl0", 32'(bus.level), 32'd0);
    chk("t5.out0", 32'(bus.out), 32'd0);
    chk("t5.empn", 32'(bus.empty_n), 32'd0);
    chk("t5.noovf", 32'(bus.overflow), 32'd0);
    chk("t5.nounf", 32'(bus.underflow), 32'd0);

    // Random traffic
    for (int c = 0; c < 10000; c++) begin
      logic p, po, fl, ce, rs;
      logic [WIDTH-1:0] d;
      p  = ($urandom_range(0, 99) < 55);
      po = ($urandom_range(0, 99) < 50);
      fl = ($urandom_range(0, 63) == 0);
      ce = ($urandom_range(0, 15) == 0);
      rs = ($urandom_range(0, 999) == 0);
      d  = WIDTH'($urandom);
      step("rnd", p, d, po, fl, ce, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
